// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT sequencing and the IF/ID
// pipeline register, with redirect, stall, flush and halt-word handling.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pcsrc_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] pcp4_q, pcp4_nxt;
  logic        valid_q, valid_nxt;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        in_run;
  logic        halt_fetch;

  assign pc_plus4 = pc_q + 32'd4;
  assign in_run   = (state_q == StRun);
  // Halt only commits when nothing else would move or redirect the pipe this cycle.
  assign halt_fetch = in_run && (imem_rd == HALT_WORD) && !stall_f && !stall_d && !pcsrc_e;

  // Next PC, sticky misalignment flag and FSM transitions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;

    if (pcsrc_e) begin
      pc_d = {pc_target_e[31:2], 2'b00};
      if (pc_target_e[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (!stall_f && in_run && !halt_fetch) begin
      pc_d = pc_plus4;
    end

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (halt_fetch) state_d = StHalt;
      // A redirect cancels a speculative halt.
      StHalt:  if (pcsrc_e) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // IF/ID register next value and retired-fetch counter.
  always_comb begin
    instr_nxt = instr_q;
    pcp4_nxt  = pcp4_q;
    valid_nxt = valid_q;
    count_d   = count_q;

    if (flush_d) begin
      instr_nxt = 32'd0;
      pcp4_nxt  = 32'd0;
      valid_nxt = 1'b0;
    end else if (!stall_d) begin
      if (in_run) begin
        instr_nxt = imem_rd;
        pcp4_nxt  = pc_plus4;
        valid_nxt = 1'b1;
        count_d   = count_q + 32'd1;
      end else begin
        instr_nxt = 32'd0;
        pcp4_nxt  = 32'd0;
        valid_nxt = 1'b0;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pcp4_q     <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_nxt;
      pcp4_q     <= pcp4_nxt;
      valid_q    <= valid_nxt;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_a       = pc_q;
  assign pc_f         = pc_q;
  assign instr_d      = instr_q;
  assign pc_plus4_d   = pcp4_q;
  assign valid_d      = valid_q;
  assign halted       = (state_q == StHalt);
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a scoreboard of expected IF/ID loads.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        stall_f, stall_d, flush_d, pcsrc_e;
  logic [31:0] pc_target_e;
  logic [31:0] pc_f, instr_d, pc_plus4_d, fetch_count;
  logic        valid_d, halted, misalign_err;

  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = 32'd0;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  // Memory returns the word index, or the halt word at one chosen address.
  assign imem_rd = (halt_en && imem_a == halt_addr) ? 32'hFFFF_FFFF : {2'b00, imem_a[31:2]};

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_a       (imem_a),
    .imem_rd      (imem_rd),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .pcsrc_e      (pcsrc_e),
    .pc_target_e  (pc_target_e),
    .pc_f         (pc_f),
    .instr_d      (instr_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d),
    .halted       (halted),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pcp4);
    sb_q.push_back({instr, pcp4});
  endtask

  // Advance one cycle; when a load is expected, pop and compare the IF/ID contents.
  task automatic tick(input bit ld);
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (ld) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", instr_d, e[63:32]);
        chk("sb_pcp4", pc_plus4_d, e[31:0]);
        chk("sb_valid", {31'd0, valid_d}, 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pcsrc_e = 1'b0; pc_target_e = 32'd0;

    // Reset state
    tick(0);
    chk("rst_pc", pc_f, 32'd0);
    chk("rst_imem_a", imem_a, 32'd0);
    chk("rst_instr", instr_d, 32'd0);
    chk("rst_pcp4", pc_plus4_d, 32'd0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // BOOT: PC holds, bubble loaded
    rst = 1'b0;
    tick(0);
    chk("boot_pc", pc_f, 32'd0);
    chk("boot_valid", {31'd0, valid_d}, 32'd0);

    // Free run
    push(32'd0, 32'd4); tick(1);
    chk("run_pc4", pc_f, 32'd4);
    chk("run_cnt1", fetch_count, 32'd1);
    push(32'd1, 32'd8); tick(1);
    chk("run_pc8", pc_f, 32'd8);
    chk("run_imem_a", imem_a, 32'd8);
    chk("run_cnt2", fetch_count, 32'd2);

    // Full stall, flush on the last stalled cycle
    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(0);
      chk("stall_pc", pc_f, 32'd8);
      chk("stall_instr", instr_d, 32'd1);
      chk("stall_valid", {31'd0, valid_d}, 32'd1);
      chk("stall_cnt", fetch_count, 32'd2);
    end
    flush_d = 1'b1;
    tick(0);
    chk("flush_pc", pc_f, 32'd8);
    chk("flush_valid", {31'd0, valid_d}, 32'd0);
    chk("flush_instr", instr_d, 32'd0);
    chk("flush_cnt", fetch_count, 32'd2);
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    push(32'd2, 32'd12); tick(1);
    chk("resume_pc", pc_f, 32'd12);
    chk("resume_cnt", fetch_count, 32'd3);

    // Redirect beats stall_f
    stall_f = 1'b1; pcsrc_e = 1'b1; pc_target_e = 32'h40;
    push(32'd3, 32'd16); tick(1);
    chk("redir_pc", pc_f, 32'h40);
    chk("redir_mis0", {31'd0, misalign_err}, 32'd0);
    stall_f = 1'b0; pc_target_e = 32'h43;
    push(32'h10, 32'h44); tick(1);
    chk("mis_pc", pc_f, 32'h40);
    chk("mis_flag", {31'd0, misalign_err}, 32'd1);
    pcsrc_e = 1'b0;
    push(32'h10, 32'h44); tick(1);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
    chk("mis_next_pc", pc_f, 32'h44);
    chk("mis_cnt", fetch_count, 32'd6);

    // Halt word at 0x10
    halt_en = 1'b1; halt_addr = 32'h10;
    pcsrc_e = 1'b1; pc_target_e = 32'h10;
    push(32'h11, 32'h48); tick(1);
    chk("pre_halt_pc", pc_f, 32'h10);
    pcsrc_e = 1'b0;
    push(32'hFFFF_FFFF, 32'h14); tick(1);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc_f, 32'h10);
    chk("halt_cnt", fetch_count, 32'd8);
    for (int i = 0; i < 2; i++) begin
      tick(0);
      chk("halt_hold_pc", pc_f, 32'h10);
      chk("halt_bubble_valid", {31'd0, valid_d}, 32'd0);
      chk("halt_bubble_instr", instr_d, 32'd0);
      chk("halt_hold_flag", {31'd0, halted}, 32'd1);
      chk("halt_hold_cnt", fetch_count, 32'd8);
    end
    pcsrc_e = 1'b1; pc_target_e = 32'h20;
    tick(0);
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_pc", pc_f, 32'h20);
    chk("unhalt_valid", {31'd0, valid_d}, 32'd0);
    pcsrc_e = 1'b0;
    push(32'd8, 32'h24); tick(1);
    chk("unhalt_run_pc", pc_f, 32'h24);
    chk("unhalt_cnt", fetch_count, 32'd9);

    // Halt word seen under stall_f: stays RUN until the stall clears
    halt_addr = 32'h24; stall_f = 1'b1;
    push(32'hFFFF_FFFF, 32'h28); tick(1);
    chk("stl_halt_flag", {31'd0, halted}, 32'd0);
    chk("stl_halt_pc", pc_f, 32'h24);
    stall_f = 1'b0;
    push(32'hFFFF_FFFF, 32'h28); tick(1);
    chk("stl_halt_now", {31'd0, halted}, 32'd1);
    chk("stl_halt_pc2", pc_f, 32'h24);
    chk("stl_halt_cnt", fetch_count, 32'd11);

    // Reset overrides redirect and stalls while halted
    rst = 1'b1; pcsrc_e = 1'b1; pc_target_e = 32'h80; stall_f = 1'b1; stall_d = 1'b1;
    tick(0);
    chk("rst2_pc", pc_f, 32'd0);
    chk("rst2_cnt", fetch_count, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_valid", {31'd0, valid_d}, 32'd0);
    chk("rst2_instr", instr_d, 32'd0);
    chk("rst2_misalign", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0; pcsrc_e = 1'b0; stall_f = 1'b0; stall_d = 1'b0; halt_en = 1'b0;
    tick(0);
    chk("boot2_pc", pc_f, 32'd0);

    // PC wraps at the top of the address space
    pcsrc_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    push(32'd0, 32'd4); tick(1);
    chk("wrap_pre_pc", pc_f, 32'hFFFF_FFFC);
    pcsrc_e = 1'b0;
    push(32'h3FFF_FFFF, 32'd0); tick(1);
    chk("wrap_pc", pc_f, 32'd0);
    chk("wrap_cnt", fetch_count, 32'd2);

    // stall_d alone: PC advances, IF/ID holds
    stall_d = 1'b1;
    tick(0);
    chk("sd_pc", pc_f, 32'd4);
    chk("sd_instr", instr_d, 32'h3FFF_FFFF);
    chk("sd_cnt", fetch_count, 32'd2);
    stall_d = 1'b0;

    chk("sb_leftover", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
